// File: rtl/tmr_sipo_receiver_pkg.sv
// -----------------------------------------------------------------------------
// tmr_rx_pkg
// Shared types and helpers for the triple-redundant serial-to-parallel
// receiver.
//   rx_state_t      : per-core receiver state (IDLE / SHIFT / HOLD)
//   LSB_FIRST/MSB_FIRST : encodings of the bit_order input
//   maj3()          : 2-of-3 majority of one bit; vectors of any width are
//                     voted by applying it bit by bit in a generate loop
// -----------------------------------------------------------------------------
package tmr_rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } rx_state_t;

    localparam logic LSB_FIRST = 1'b0;
    localparam logic MSB_FIRST = 1'b1;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage : tmr_rx_pkg

// File: rtl/tmr_sipo_receiver_if.sv
// -----------------------------------------------------------------------------
// tmr_sipo_receiver_if
// Serial input strobe/data, word handshake and status signals of the TMR
// SIPO receiver.
//   master : drives the serial stream and word_ready, observes the word side
//   slave  : the receiver itself
// Signals:
//   enable, serial_in, frame_start, bit_order : serial side (to receiver)
//   word_ready                                : downstream accept (to receiver)
//   word_out, word_valid                      : assembled word (from receiver)
//   overrun, resync, tmr_error                : status (from receiver)
// -----------------------------------------------------------------------------
interface tmr_sipo_receiver_if #(
    parameter int width = 32
);
    logic             enable;
    logic             serial_in;
    logic             frame_start;
    logic             bit_order;
    logic             word_ready;
    logic [width-1:0] word_out;
    logic             word_valid;
    logic             overrun;
    logic             resync;
    logic             tmr_error;

    modport master (
        output enable, serial_in, frame_start, bit_order, word_ready,
        input  word_out, word_valid, overrun, resync, tmr_error
    );

    modport slave (
        input  enable, serial_in, frame_start, bit_order, word_ready,
        output word_out, word_valid, overrun, resync, tmr_error
    );
endinterface : tmr_sipo_receiver_if

// File: rtl/tmr_sipo_receiver_core.sv
// -----------------------------------------------------------------------------
// tmr_rx_core
// One receiver lane: frame detection, bit counter, shift register and the
// output word holding register. Three of these run in lockstep.
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   i_enable            : bit strobe
//   i_serial_in         : serial data
//   i_frame_start       : first bit of a frame is on i_serial_in
//   i_bit_order         : 0 = LSB first, 1 = MSB first (taken at frame start)
//   i_word_ready        : downstream accepts o_word
//   o_state, o_count, o_sr : internal state, exported for mismatch compare
//   o_word, o_valid     : assembled word and its valid flag
//   o_overrun, o_resync : one-cycle status pulses
// -----------------------------------------------------------------------------
module tmr_rx_core
    import tmr_rx_pkg::*;
#(
    parameter  int width = 32,
    localparam int CNT_W = $clog2(width)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_enable,
    input  logic             i_serial_in,
    input  logic             i_frame_start,
    input  logic             i_bit_order,
    input  logic             i_word_ready,
    output rx_state_t        o_state,
    output logic [CNT_W-1:0] o_count,
    output logic [width-1:0] o_sr,
    output logic [width-1:0] o_word,
    output logic             o_valid,
    output logic             o_overrun,
    output logic             o_resync
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(width - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    rx_state_t        r_state,   w_state_next;
    logic [CNT_W-1:0] r_count,   w_count_next;
    logic [width-1:0] r_sr,      w_sr_next;
    logic [width-1:0] r_word,    w_word_next;
    logic             r_valid,   w_valid_next;
    logic             r_overrun, w_overrun_next;
    logic             r_resync,  w_resync_next;
    logic             r_order,   w_order_next;

    logic             w_start;
    logic [width-1:0] w_sr_shift;
    logic [width-1:0] w_sr_first;

    assign w_start = i_enable & i_frame_start;

    // Shift uses the order latched at frame start.
    assign w_sr_shift = (r_order == LSB_FIRST) ? {i_serial_in, r_sr[width-1:1]}
                                               : {r_sr[width-2:0], i_serial_in};

    // A new frame discards whatever was in the shift register, so the first
    // bit is loaded into a cleared register at the end it enters from.
    assign w_sr_first = (i_bit_order == LSB_FIRST) ? {i_serial_in, {(width-1){1'b0}}}
                                                   : {{(width-1){1'b0}}, i_serial_in};

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_sr      <= '0;
            r_word    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
            r_resync  <= 1'b0;
            r_order   <= LSB_FIRST;
        end else begin
            r_state   <= w_state_next;
            r_count   <= w_count_next;
            r_sr      <= w_sr_next;
            r_word    <= w_word_next;
            r_valid   <= w_valid_next;
            r_overrun <= w_overrun_next;
            r_resync  <= w_resync_next;
            r_order   <= w_order_next;
        end
    end

    // Next-state and datapath logic
    always_comb begin
        w_state_next   = r_state;
        w_count_next   = r_count;
        w_sr_next      = r_sr;
        w_word_next    = r_word;
        w_valid_next   = r_valid;
        w_order_next   = r_order;
        w_overrun_next = 1'b0;
        w_resync_next  = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_state_next = SHIFT;
                    w_order_next = i_bit_order;
                    w_sr_next    = w_sr_first;
                    w_count_next = ONE;
                end
            end

            SHIFT: begin
                if (w_start) begin
                    // Restart on the new frame; the partial word is lost.
                    w_order_next  = i_bit_order;
                    w_sr_next     = w_sr_first;
                    w_count_next  = ONE;
                    w_resync_next = 1'b1;
                end else if (i_enable) begin
                    w_sr_next = w_sr_shift;
                    if (r_count == LAST_BIT) begin
                        w_state_next = HOLD;
                        w_word_next  = w_sr_shift;
                        w_valid_next = 1'b1;
                        w_count_next = '0;
                    end else begin
                        w_count_next = r_count + ONE;
                    end
                end
            end

            HOLD: begin
                if (i_word_ready) begin
                    w_valid_next = 1'b0;
                    if (w_start) begin
                        // Handshake and new frame in the same cycle.
                        w_state_next = SHIFT;
                        w_order_next = i_bit_order;
                        w_sr_next    = w_sr_first;
                        w_count_next = ONE;
                    end else begin
                        w_state_next = IDLE;
                    end
                end else if (w_start) begin
                    // No room for a new frame: drop it, keep the pending word.
                    w_overrun_next = 1'b1;
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Outputs
    always_comb begin
        o_state   = r_state;
        o_count   = r_count;
        o_sr      = r_sr;
        o_word    = r_word;
        o_valid   = r_valid;
        o_overrun = r_overrun;
        o_resync  = r_resync;
    end

endmodule : tmr_rx_core

// File: rtl/tmr_sipo_receiver.sv
// -----------------------------------------------------------------------------
// tmr_sipo_receiver
// Triple-redundant serial-to-parallel receiver. Three tmr_rx_core lanes see
// identical inputs; the word, valid and status pulses are 2-of-3 voted, and
// tmr_error is raised (registered) whenever the lanes' internal state differs.
// Faulted lanes are not scrubbed; only reset realigns them.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : tmr_sipo_receiver_if slave modport (serial side, word handshake,
//          overrun / resync / tmr_error status)
// -----------------------------------------------------------------------------
module tmr_sipo_receiver
    import tmr_rx_pkg::*;
#(
    parameter int width = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    tmr_sipo_receiver_if.slave   bus
);

    localparam int CNT_W  = $clog2(width);
    localparam int SNAP_W = 2 + CNT_W + width + width + 1;

    rx_state_t        w_state   [3];
    logic [CNT_W-1:0] w_count   [3];
    logic [width-1:0] w_sr      [3];
    logic [width-1:0] w_word    [3];
    logic             w_valid   [3];
    logic             w_overrun [3];
    logic             w_resync  [3];
    logic [SNAP_W-1:0] w_snap   [3];

    logic [width-1:0] w_word_vote;
    logic             w_mismatch;
    logic             r_tmr_error;

    genvar gi;

    generate
        for (gi = 0; gi < 3; gi++) begin : gen_core
            tmr_rx_core #(
                .width(width)
            ) u_core (
                .clk          (clk),
                .rst          (rst),
                .i_enable     (bus.enable),
                .i_serial_in  (bus.serial_in),
                .i_frame_start(bus.frame_start),
                .i_bit_order  (bus.bit_order),
                .i_word_ready (bus.word_ready),
                .o_state      (w_state[gi]),
                .o_count      (w_count[gi]),
                .o_sr         (w_sr[gi]),
                .o_word       (w_word[gi]),
                .o_valid      (w_valid[gi]),
                .o_overrun    (w_overrun[gi]),
                .o_resync     (w_resync[gi])
            );

            // Everything that must agree between lanes, packed for one compare.
            assign w_snap[gi] = {w_state[gi], w_count[gi], w_sr[gi],
                                 w_word[gi], w_valid[gi]};
        end

        for (gi = 0; gi < width; gi++) begin : gen_vote
            assign w_word_vote[gi] = maj3(w_word[0][gi], w_word[1][gi], w_word[2][gi]);
        end
    endgenerate

    assign w_mismatch = (w_snap[0] != w_snap[1]) || (w_snap[0] != w_snap[2]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tmr_error <= 1'b0;
        end else begin
            r_tmr_error <= w_mismatch;
        end
    end

    assign bus.word_out   = w_word_vote;
    assign bus.word_valid = maj3(w_valid[0],   w_valid[1],   w_valid[2]);
    assign bus.overrun    = maj3(w_overrun[0], w_overrun[1], w_overrun[2]);
    assign bus.resync     = maj3(w_resync[0],  w_resync[1],  w_resync[2]);
    assign bus.tmr_error  = r_tmr_error;

endmodule : tmr_sipo_receiver

// File: tb/tb_tmr_sipo_receiver.sv
// -----------------------------------------------------------------------------
// tb_tmr_sipo_receiver
// Directed bench for tmr_sipo_receiver (width 32). Expected words are queued
// when a frame is driven and popped when the word is taken on the handshake.
// -----------------------------------------------------------------------------
module tb_tmr_sipo_receiver;

    localparam int W = 32;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;
    int   start_cyc;
    logic s_resync0;
    logic s_resync1;
    logic s_over0;
    logic s_valid0;
    logic [W-1:0] sb[$];
    logic [W-1:0] flip_val;

    tmr_sipo_receiver_if #(.width(W)) bus ();

    tmr_sipo_receiver #(.width(W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare word_out with the oldest queued expectation and retire it.
    task automatic pop_check(input string tag);
        logic [W-1:0] exp;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=%h expected=<empty queue>", tag, bus.word_out);
        end else begin
            exp = sb.pop_front();
            chk({tag, "_valid"}, {31'd0, bus.word_valid}, 32'd1);
            chk(tag, bus.word_out, exp);
            $display("word %s got=%h exp=%h", tag, bus.word_out, exp);
        end
    endtask

    // Drive bits lo..hi of word w; bit 0 carries frame_start. With gap set an
    // enable-low cycle is inserted between consecutive bits.
    task automatic drive_bits(input logic [W-1:0] w, input logic ord, input int lo,
                              input int hi, input bit gap, input bit ready_first);
        for (int i = lo; i <= hi; i++) begin
            bus.enable      = 1'b1;
            bus.frame_start = (i == 0);
            bus.bit_order   = ord;
            bus.serial_in   = ord ? w[W-1-i] : w[i];
            if (ready_first && i == lo) bus.word_ready = 1'b1;
            if (i == 0) start_cyc = cyc;
            step();
            if (ready_first && i == lo) bus.word_ready = 1'b0;
            if (i == lo) begin
                s_resync0 = bus.resync;
                s_over0   = bus.overrun;
                s_valid0  = bus.word_valid;
            end
            if (i == lo + 1) s_resync1 = bus.resync;
            bus.frame_start = 1'b0;
            if (gap && i < hi) begin
                bus.enable = 1'b0;
                step();
            end
        end
        bus.enable      = 1'b0;
        bus.frame_start = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        bus.enable      = 1'b0;
        bus.serial_in   = 1'b0;
        bus.frame_start = 1'b0;
        bus.bit_order   = 1'b0;
        bus.word_ready  = 1'b0;

        // ---- reset state
        step();
        step();
        chk("rst_word",  bus.word_out, 32'd0);
        chk("rst_valid", {31'd0, bus.word_valid}, 32'd0);
        chk("rst_flags", {29'd0, bus.overrun, bus.resync, bus.tmr_error}, 32'd0);
        #2 rst = 1'b1;
        while (cyc < 10) step();

        // ---- LSB first, ready held high, valid for one cycle
        bus.word_ready = 1'b1;
        sb.push_back(32'hA5A5_0F0F);
        drive_bits(32'hA5A5_0F0F, 1'b0, 0, 31, 1'b0, 1'b0);
        chk("t1_latency", 32'(cyc - start_cyc), 32'd32);
        chk("t1_start_resync", {31'd0, s_resync0}, 32'd0);
        pop_check("t1_word");
        chk("t1_tmr", {31'd0, bus.tmr_error}, 32'd0);
        step();
        chk("t1_valid_drop", {31'd0, bus.word_valid}, 32'd0);
        bus.word_ready = 1'b0;

        // ---- MSB first with enable gaps, word held until ready
        sb.push_back(32'h8000_0001);
        drive_bits(32'h8000_0001, 1'b1, 0, 31, 1'b1, 1'b0);
        chk("t2_latency", 32'(cyc - start_cyc), 32'd63);
        for (int k = 0; k < 4; k++) step();
        chk("t2_hold_valid", {31'd0, bus.word_valid}, 32'd1);
        chk("t2_hold_word", bus.word_out, sb[0]);
        bus.word_ready = 1'b1;
        pop_check("t2_word");
        step();
        bus.word_ready = 1'b0;
        chk("t2_valid_drop", {31'd0, bus.word_valid}, 32'd0);

        // ---- overrun while pending, then frame start on the handshake
        sb.push_back(32'h1234_5678);
        drive_bits(32'h1234_5678, 1'b0, 0, 31, 1'b0, 1'b0);
        bus.enable = 1'b1;
        bus.frame_start = 1'b1;
        bus.serial_in = 1'b1;
        step();
        chk("t3_overrun", {31'd0, bus.overrun}, 32'd1);
        chk("t3_word_kept", bus.word_out, sb[0]);
        bus.frame_start = 1'b0;
        bus.serial_in = 1'b0;
        step();
        bus.enable = 1'b0;
        chk("t3_overrun_pulse", {31'd0, bus.overrun}, 32'd0);
        chk("t3_still_valid", {31'd0, bus.word_valid}, 32'd1);
        pop_check("t3_word_a");
        sb.push_back(32'hDEAD_BEEF);
        drive_bits(32'hDEAD_BEEF, 1'b0, 0, 31, 1'b0, 1'b1);
        chk("t3_hs_valid", {31'd0, s_valid0}, 32'd0);
        chk("t3_hs_no_over", {31'd0, s_over0}, 32'd0);
        chk("t3_latency", 32'(cyc - start_cyc), 32'd32);
        bus.word_ready = 1'b1;
        pop_check("t3_word_b");
        step();
        bus.word_ready = 1'b0;

        // ---- resync: new frame_start where bit 17 would be
        drive_bits(32'hFFFF_FFFF, 1'b0, 0, 16, 1'b0, 1'b0);
        sb.push_back(32'h0BAD_CAFE);
        drive_bits(32'h0BAD_CAFE, 1'b1, 0, 31, 1'b0, 1'b0);
        chk("t4_resync", {31'd0, s_resync0}, 32'd1);
        chk("t4_resync_pulse", {31'd0, s_resync1}, 32'd0);
        chk("t4_latency", 32'(cyc - start_cyc), 32'd32);
        bus.word_ready = 1'b1;
        pop_check("t4_word");
        step();
        bus.word_ready = 1'b0;

        // ---- single-lane upset: vote masks it, tmr_error flags it
        sb.push_back(32'hC3A5_9617);
        drive_bits(32'hC3A5_9617, 1'b1, 0, 16, 1'b0, 1'b0);
        flip_val = dut.gen_core[0].u_core.r_sr ^ 32'h20;
        force dut.gen_core[0].u_core.r_sr = flip_val;
        #1;
        release dut.gen_core[0].u_core.r_sr;
        chk("t5_tmr_before", {31'd0, bus.tmr_error}, 32'd0);
        drive_bits(32'hC3A5_9617, 1'b1, 17, 31, 1'b0, 1'b0);
        chk("t5_tmr_set", {31'd0, bus.tmr_error}, 32'd1);
        bus.word_ready = 1'b1;
        pop_check("t5_word");
        step();
        bus.word_ready = 1'b0;
        chk("t5_tmr_sticky", {31'd0, bus.tmr_error}, 32'd1);

        // ---- same upset in two lanes: outvotes the good lane
        sb.push_back(32'h5A5A_3C3C ^ 32'h0010_0000);
        drive_bits(32'h5A5A_3C3C, 1'b1, 0, 16, 1'b0, 1'b0);
        flip_val = dut.gen_core[0].u_core.r_sr ^ 32'h20;
        force dut.gen_core[0].u_core.r_sr = flip_val;
        flip_val = dut.gen_core[1].u_core.r_sr ^ 32'h20;
        force dut.gen_core[1].u_core.r_sr = flip_val;
        #1;
        release dut.gen_core[0].u_core.r_sr;
        release dut.gen_core[1].u_core.r_sr;
        drive_bits(32'h5A5A_3C3C, 1'b1, 17, 31, 1'b0, 1'b0);
        chk("t6_tmr_set", {31'd0, bus.tmr_error}, 32'd1);
        bus.word_ready = 1'b1;
        pop_check("t6_word_corrupt");
        step();
        bus.word_ready = 1'b0;

        // ---- asynchronous reset mid-frame
        drive_bits(32'h7777_1111, 1'b0, 0, 9, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk("t7_rst_word", bus.word_out, 32'd0);
        chk("t7_rst_valid", {31'd0, bus.word_valid}, 32'd0);
        chk("t7_rst_flags", {29'd0, bus.overrun, bus.resync, bus.tmr_error}, 32'd0);
        #2 rst = 1'b1;
        step();
        chk("t7_exit_flags", {29'd0, bus.overrun, bus.resync, bus.word_valid}, 32'd0);
        sb.push_back(32'h2468_ACE1);
        drive_bits(32'h2468_ACE1, 1'b1, 0, 31, 1'b0, 1'b0);
        chk("t7_latency", 32'(cyc - start_cyc), 32'd32);
        chk("t7_tmr", {31'd0, bus.tmr_error}, 32'd0);
        bus.word_ready = 1'b1;
        pop_check("t7_word");
        step();
        bus.word_ready = 1'b0;
        chk("t7_valid_drop", {31'd0, bus.word_valid}, 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_tmr_sipo_receiver
